sll8: RTL and testbench

- Registered 8-bit logical left shifter (barrel shifter) for the datapath ALU shift unit.
- Shifts operand A left by the unsigned amount in B and zero-fills from the LSB.
- Result is captured in an output register: one clock of latency, one result per cycle.
- Shift amounts of WIDTH or more produce all zeros.

---
 rtl/alu_pkg.sv | 9 +
 rtl/sll8_stage.sv | 14 +
 rtl/sll8.sv | 50 +++++
 tb/tb_sll8.sv | 105 ++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the datapath ALU shift unit
//   WIDTH      operand/result width
//   SHAMT_LOG2 number of log shift stages (bits of B that select a distance)
//   word_t     WIDTH-bit unsigned vector
package alu_pkg;
    localparam int WIDTH = 8;
    localparam int SHAMT_LOG2 = 3;
    typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/sll8_stage.sv
// sll8_stage: one mux layer of the log shifter, shifts left by K when sel is set
//   sel  in  1      apply the shift
//   d    in  WIDTH  stage input
//   q    out WIDTH  d << K (zero-filled) when sel, else d
module sll8_stage #(
    parameter int WIDTH = 8,
    parameter int K = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_comb q = sel ? {d[WIDTH-1-K:0], {K{1'b0}}} : d;
endmodule

// File: rtl/sll8.sv
// sll8: registered logical left shifter, C <= A << B one cycle after in_valid
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   in_valid  in  1      sample A/B on this edge
//   A         in  WIDTH  operand
//   B         in  WIDTH  unsigned shift amount; B >= WIDTH gives zero
//   C         out WIDTH  registered result
//   out_valid out 1      C holds the result of the previous cycle's request
module sll8
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             out_valid
);
    logic [WIDTH-1:0] st [0:SHAMT_LOG2];
    logic [WIDTH-1:0] res;

    assign st[0] = A;

    genvar i;
    generate
        for (i = 0; i < SHAMT_LOG2; i++) begin : g_stage
            sll8_stage #(.WIDTH(WIDTH), .K(1 << i)) u_stage (
                .sel(B[i]),
                .d  (st[i]),
                .q  (st[i+1])
            );
        end
    endgenerate

    // Any upper bit of B means the distance is at least WIDTH: nothing survives.
    always_comb res = |B[WIDTH-1:SHAMT_LOG2] ? '0 : st[SHAMT_LOG2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) C <= res;
        end
    end
endmodule

// File: tb/tb_sll8.sv
// tb_sll8: directed and random self-checking bench for sll8
module tb_sll8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [7:0] C;
    logic       out_valid;
    int         n_cmp = 0;
    int         n_bad = 0;

    sll8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .C        (C),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic send(input logic v, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep [0:7] = '{8'b10110101, 8'b01101010, 8'b11010100, 8'b10101000,
                                8'b01010000, 8'b10100000, 8'b01000000, 8'b10000000};

    initial begin
        logic [7:0] a, b, e;
        #2;
        check("reset_c", C, 8'h00);
        check("reset_valid", {7'b0, out_valid}, 8'h00);
        send(1'b1, 8'hFF, 8'h00);
        check("reset_no_capture", C, 8'h00);
        check("reset_no_capture_valid", {7'b0, out_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 8'b10110101, 8'(i));
            check($sformatf("sweep_b%0d", i), C, sweep[i]);
            check($sformatf("sweep_valid%0d", i), {7'b0, out_valid}, 8'h01);
        end
        send(1'b1, 8'b10110101, 8'd8);
        check("over_b8", C, 8'h00);
        send(1'b1, 8'h01, 8'h00);
        check("restore", C, 8'h01);
        send(1'b1, 8'b10110101, 8'h62);
        check("over_b62", C, 8'h00);
        send(1'b1, 8'h01, 8'h00);
        send(1'b1, 8'hFF, 8'hFF);
        check("over_ff", C, 8'h00);
        send(1'b1, 8'h01, 8'd1);
        check("tput0", C, 8'h02);
        check("tput0_valid", {7'b0, out_valid}, 8'h01);
        send(1'b1, 8'h01, 8'd7);
        check("tput1", C, 8'h80);
        check("tput1_valid", {7'b0, out_valid}, 8'h01);
        send(1'b1, 8'h80, 8'd0);
        check("tput2", C, 8'h80);
        check("tput2_valid", {7'b0, out_valid}, 8'h01);
        send(1'b1, 8'b10110101, 8'd1);
        check("hold_pre", C, 8'h6A);
        send(1'b0, 8'h00, 8'h03);
        check("hold_c", C, 8'h6A);
        check("hold_valid", {7'b0, out_valid}, 8'h00);
        send(1'b0, 8'h00, 8'hxx);
        check("hold_x_c", C, 8'h6A);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_c", C, 8'h00);
        check("async_reset_valid", {7'b0, out_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = (i % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            e = (b >= 8) ? 8'h00 : 8'((a << b) & 8'hFF);
            send(1'b1, a, b);
            check($sformatf("rand%0d_a%02h_b%02h", i, a, b), C, e);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
